md4hashchecker: RTL and testbench

//   Responder side of the generator-to-checker handshake. Accepts a 128-bit

---
 rtl/md4hashchecker.sv | 125 ++++++++++++
 tb/tb_md4hashchecker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md4hashchecker.sv
// MD4 digest checker: scans a table of target hashes, one slot per clock,
// and answers each accepted check request with a single verdict pulse.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   checker_checkrdy    one-cycle request pulse; checker_next_hash is valid
//   checker_next_hash   128-bit byte-swapped digest to look up
//   tgt_we/waddr/wdata  write one target slot and mark it valid
//   tgt_clear           invalidate every slot (wins over tgt_we)
//   checker_resultrdy   one-cycle verdict pulse
//   checker_matchfound  verdict, held until the next accepted request
//   match_index         lowest matching slot (meaningful when matchfound)
//   busy                high while a scan or response is in flight
//   match_count         saturating number of matches since reset

module md4hashchecker #(
    parameter int NUM_TARGETS = 8,
    parameter int IDX_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             checker_checkrdy,
    input  logic [127:0]     checker_next_hash,
    input  logic             tgt_we,
    input  logic [IDX_W-1:0] tgt_waddr,
    input  logic [127:0]     tgt_wdata,
    input  logic             tgt_clear,
    output logic             checker_resultrdy,
    output logic             checker_matchfound,
    output logic [IDX_W-1:0] match_index,
    output logic             busy,
    output logic [15:0]      match_count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } state_t;

    state_t               state_q;
    logic [127:0]         hash_q;
    logic [IDX_W-1:0]     idx_q;
    logic [127:0]         slot_q [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] valid_q;

    logic hit;
    logic last;

    // The compare reads the registered table, so a write landing on the
    // same edge only becomes visible to later compares.
    assign hit  = valid_q[idx_q] && (slot_q[idx_q] == hash_q);
    assign last = (idx_q == IDX_W'(NUM_TARGETS - 1));

    // Hash storage carries no reset; validity alone decides what can match.
    always_ff @(posedge clk) begin
        if (tgt_we && !tgt_clear) begin
            slot_q[tgt_waddr] <= tgt_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (tgt_clear) begin
            valid_q <= '0;
        end else if (tgt_we) begin
            valid_q[tgt_waddr] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            hash_q             <= '0;
            idx_q              <= '0;
            checker_resultrdy  <= 1'b0;
            checker_matchfound <= 1'b0;
            match_index        <= '0;
            busy               <= 1'b0;
            match_count        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (checker_checkrdy) begin
                        hash_q             <= checker_next_hash;
                        idx_q              <= '0;
                        busy               <= 1'b1;
                        checker_matchfound <= 1'b0;
                        state_q            <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        checker_matchfound <= 1'b1;
                        match_index        <= idx_q;
                        checker_resultrdy  <= 1'b1;
                        state_q            <= RESP;
                        if (match_count != 16'hFFFF) begin
                            match_count <= match_count + 16'd1;
                        end
                    end else if (last) begin
                        checker_matchfound <= 1'b0;
                        checker_resultrdy  <= 1'b1;
                        state_q            <= RESP;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                RESP: begin
                    // A request arriving here is dropped, not queued.
                    checker_resultrdy <= 1'b0;
                    busy              <= 1'b0;
                    state_q           <= IDLE;
                end
                default: begin
                    checker_resultrdy <= 1'b0;
                    busy              <= 1'b0;
                    state_q           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md4hashchecker.sv
// Testbench for md4hashchecker: vector table plus hand-written sequences,
// with a scoreboard of expected verdicts checked on every result pulse.

module tb_md4hashchecker;

    localparam int N  = 8;
    localparam int IW = 3;

    localparam logic [127:0] H1 = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
    localparam logic [127:0] HX = 128'h0123456789abcdef0011223344556677;
    localparam logic [127:0] HY = 128'hdeadbeefcafef00d5555aaaa12345678;
    localparam logic [127:0] HZ = 128'h8899aabbccddeeff0f1e2d3c4b5a6978;
    localparam logic [127:0] HW = 128'hfeedface000011112222333344445555;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           checkrdy = 1'b0;
    logic [127:0]   next_hash = '0;
    logic           tgt_we = 1'b0;
    logic [IW-1:0]  tgt_waddr = '0;
    logic [127:0]   tgt_wdata = '0;
    logic           tgt_clear = 1'b0;
    logic           resultrdy;
    logic           matchfound;
    logic [IW-1:0]  match_index;
    logic           busy;
    logic [15:0]    match_count;

    md4hashchecker #(.NUM_TARGETS(N), .IDX_W(IW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .checker_checkrdy   (checkrdy),
        .checker_next_hash  (next_hash),
        .tgt_we             (tgt_we),
        .tgt_waddr          (tgt_waddr),
        .tgt_wdata          (tgt_wdata),
        .tgt_clear          (tgt_clear),
        .checker_resultrdy  (resultrdy),
        .checker_matchfound (matchfound),
        .match_index        (match_index),
        .busy               (busy),
        .match_count        (match_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic          found;
        logic [IW-1:0] idx;
        int            cyc;
    } exp_t;

    typedef struct {
        logic [127:0]  hash;
        logic          found;
        logic [IW-1:0] idx;
    } vec_t;

    exp_t        sb[$];
    exp_t        e;
    vec_t        vt[5];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_count = '0;
    logic        prev_rdy = 1'b0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every result pulse must match the oldest request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (resultrdy) begin
                chk("pulse_width", {127'd0, prev_rdy}, 128'd0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resultrdy: got pulse at cycle %0d want none", cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.found && exp_count != 16'hFFFF) exp_count++;
                    chk("latency_cycle", 128'(cyc), 128'(e.cyc));
                    chk("matchfound", {127'd0, matchfound}, {127'd0, e.found});
                    if (e.found) chk("match_index", 128'(match_index), 128'(e.idx));
                    chk("match_count", 128'(match_count), 128'(exp_count));
                end
            end
            prev_rdy = resultrdy;
        end else begin
            prev_rdy = 1'b0;
        end
    end

    task automatic load(input logic [IW-1:0] a, input logic [127:0] d);
        @(posedge clk);
        #1;
        tgt_we    = 1'b1;
        tgt_waddr = a;
        tgt_wdata = d;
        @(posedge clk);
        #1;
        tgt_we = 1'b0;
    endtask

    // Drives a one-cycle request; the sampling edge is the next posedge.
    task automatic start_check(input logic [127:0] h, input logic f,
                               input logic [IW-1:0] i);
        exp_t x;
        @(posedge clk);
        #1;
        checkrdy  = 1'b1;
        next_hash = h;
        x.found   = f;
        x.idx     = i;
        x.cyc     = cyc + 1 + (f ? int'(i) + 1 : N);
        sb.push_back(x);
        @(posedge clk);
        #1;
        checkrdy = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL result_timeout: got %0d pending want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic do_check(input logic [127:0] h, input logic f,
                            input logic [IW-1:0] i);
        start_check(h, f, i);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic [127:0] hk;

        vt[0] = '{hash: HX,  found: 1'b1, idx: 3'd5};
        vt[1] = '{hash: H1,  found: 1'b1, idx: 3'd0};
        vt[2] = '{hash: '0,  found: 1'b0, idx: 3'd0};
        vt[3] = '{hash: HZ,  found: 1'b0, idx: 3'd0};
        vt[4] = '{hash: ~H1, found: 1'b0, idx: 3'd0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resultrdy", {127'd0, resultrdy}, 128'd0);
        chk("rst_matchfound", {127'd0, matchfound}, 128'd0);
        chk("rst_match_index", 128'(match_index), 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_match_count", 128'(match_count), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Empty table: even an all-zero hash misses.
        do_check('0, 1'b0, '0);

        load(3'd0, H1);
        do_check(H1, 1'b1, 3'd0);

        load(3'd5, HX);
        load(3'd7, HX);
        do_check(HX, 1'b1, 3'd5);
        repeat (10) begin
            @(negedge clk);
            chk("hold_matchfound", {127'd0, matchfound}, 128'd1);
            chk("hold_match_index", 128'(match_index), 128'd5);
        end

        for (int k = 0; k < 5; k++) begin
            do_check(vt[k].hash, vt[k].found, vt[k].idx);
        end

        // Requests during SCAN and in the RESP cycle are dropped.
        start_check('0, 1'b0, '0);
        @(negedge clk);
        chk("busy_in_scan", {127'd0, busy}, 128'd1);
        @(posedge clk);
        #1;
        checkrdy  = 1'b1;
        next_hash = H1;
        @(posedge clk);
        #1;
        checkrdy = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (resultrdy) begin
                seen = 1'b1;
                break;
            end
        end
        chk("first_result_seen", {127'd0, seen}, 128'd1);
        checkrdy  = 1'b1;
        next_hash = H1;
        @(posedge clk);
        #1;
        checkrdy = 1'b0;
        repeat (12) @(negedge clk);
        chk("dropped_busy", {127'd0, busy}, 128'd0);
        chk("dropped_matchfound", {127'd0, matchfound}, 128'd0);
        chk("dropped_pending", 128'(sb.size()), 128'd0);

        // Write slot3 on the edge that compares slot3: old contents win.
        start_check(HY, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        tgt_we    = 1'b1;
        tgt_waddr = 3'd3;
        tgt_wdata = HY;
        @(posedge clk);
        #1;
        tgt_we = 1'b0;
        wait_done();
        do_check(HY, 1'b1, 3'd3);

        for (int k = 0; k < N; k++) begin
            hk = HZ ^ 128'(k * 7 + 1);
            load(IW'(k), hk);
        end
        do_check(HZ ^ 128'd15, 1'b1, 3'd2);

        // Clear wins over a simultaneous write.
        @(posedge clk);
        #1;
        tgt_clear = 1'b1;
        tgt_we    = 1'b1;
        tgt_waddr = 3'd1;
        tgt_wdata = HW;
        @(posedge clk);
        #1;
        tgt_clear = 1'b0;
        tgt_we    = 1'b0;
        do_check(HZ ^ 128'd15, 1'b0, '0);
        do_check(HW, 1'b0, '0);

        // Reset in mid-scan: no pulse, everything back to zero.
        load(3'd6, HX);
        start_check(HX, 1'b1, 3'd6);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        exp_count = '0;
        #1;
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        chk("midrst_resultrdy", {127'd0, resultrdy}, 128'd0);
        chk("midrst_matchfound", {127'd0, matchfound}, 128'd0);
        chk("midrst_match_count", 128'(match_count), 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_idle_busy", {127'd0, busy}, 128'd0);
        // Storage survives reset but validity does not.
        do_check(HX, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
